// File: rtl/srt_div_scheduler.sv
// Round-robin scheduler for one shared FP32 SRT radix-4 divider; a response is valid ITER+2 cycles after the accept cycle
// and is held in DONE while resp_ready_i is low. `SRT_SCHED_SPECIAL_EN` enables the IEEE special-operand bypass.
module srt_div_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ITER    = 13,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_dividend_i,
  input  logic [NUM_REQ*32-1:0] req_divisor_i,
  output logic                  div_load_o,
  output logic [31:0]           div_dividend_o,
  output logic [31:0]           div_divisor_o,
  input  logic [31:0]           div_quotient_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_quotient_o,
  output logic [IDW-1:0]        resp_id_o,
  output logic                  busy_o
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITERATE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    dividend_q, dividend_d;
  logic [31:0]    divisor_q, divisor_d;
  logic [31:0]    quot_q, quot_d;
  logic [IDW-1:0] id_q, id_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan_idx;
  logic [31:0]    gnt_a, gnt_b;
  logic           sp_hit;
  logic [31:0]    sp_res;

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  assign gnt_a = req_dividend_i[{gnt_id, 5'b00000} +: 32];
  assign gnt_b = req_divisor_i[{gnt_id, 5'b00000} +: 32];

`ifdef SRT_SCHED_SPECIAL_EN
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, res_sign;

  assign a_nan    = (&gnt_a[30:23]) && (|gnt_a[22:0]);
  assign a_inf    = (&gnt_a[30:23]) && !(|gnt_a[22:0]);
  assign a_zero   = ~|gnt_a[30:0];
  assign b_nan    = (&gnt_b[30:23]) && (|gnt_b[22:0]);
  assign b_inf    = (&gnt_b[30:23]) && !(|gnt_b[22:0]);
  assign b_zero   = ~|gnt_b[30:0];
  assign res_sign = gnt_a[31] ^ gnt_b[31];

  // Denormals count as finite nonzero and go through the divider.
  always_comb begin
    sp_hit = 1'b1;
    sp_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = 32'h7FC0_0000;
    end else if (b_zero || a_inf) begin
      sp_res = {res_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      sp_res = {res_sign, 31'h0};
    end else begin
      sp_hit = 1'b0;
    end
  end
`else
  assign sp_hit = 1'b0;
  assign sp_res = '0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    id_d         = id_q;
    req_ready_o  = '0;
    div_load_o   = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (gnt_found) begin
          req_ready_o[gnt_id] = 1'b1;
          dividend_d = gnt_a;
          divisor_d  = gnt_b;
          id_d       = gnt_id;
          rr_ptr_d   = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          if (sp_hit) begin
            quot_d  = sp_res;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        div_load_o = 1'b1;
        cnt_d      = '0;
        state_d    = S_ITERATE;
      end
      S_ITERATE: begin
        // Hold the counter at its last value so it cannot wrap when ITER is a power of two.
        if (cnt_q == CNT_LAST) begin
          quot_d  = div_quotient_i;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      id_q       <= id_d;
    end
  end

  assign div_dividend_o  = dividend_q;
  assign div_divisor_o   = divisor_q;
  assign resp_quotient_o = quot_q;
  assign resp_id_o       = id_q;

endmodule

// File: tb/tb_srt_div_scheduler.sv
// Bench for srt_div_scheduler: a stand-in divider plus a transaction-level model checked every cycle.
module tb_srt_div_scheduler;
  localparam int N    = 4;
  localparam int ITER = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_dividend, req_divisor;
  logic          div_load;
  logic [31:0]   div_dividend, div_divisor, div_quotient;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_quotient;
  logic [1:0]    resp_id;
  logic          busy;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  assign req_dividend = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_divisor  = {op_b[3], op_b[2], op_b[1], op_b[0]};

  srt_div_scheduler #(.NUM_REQ(N), .ITER(ITER)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .div_load_o(div_load), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_quotient_i(div_quotient),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_quotient_o(resp_quotient), .resp_id_o(resp_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in divider: log-domain subtraction, exact for the power-of-two ratios used below.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], a[30:0] - b[30:0] + 31'h3F80_0000};
  endfunction

  // {hit, result} for IEEE special operand pairs.
  function automatic logic [32:0] spec_dec(input logic [31:0] a, input logic [31:0] b);
    bit an, ai, az, bn, bi, bz;
    logic s;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    ai = (a[30:0] == 31'h7F80_0000);
    az = (a[30:0] == 31'h0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    bi = (b[30:0] == 31'h7F80_0000);
    bz = (b[30:0] == 31'h0);
    s  = a[31] ^ b[31];
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 32'h7FC0_0000};
    if (bz || ai) return {1'b1, s, 31'h7F80_0000};
    if (az || bi) return {1'b1, s, 31'h0};
    return 33'd0;
  endfunction

  // The divider only presents its result in the cycle ITER cycles after the load cycle.
  int fd_cnt = 0;
  logic [31:0] fd_a, fd_b;
  always @(posedge clk) begin
    if (rst) fd_cnt <= 0;
    else if (div_load) begin
      fd_cnt <= 1;
      fd_a   <= div_dividend;
      fd_b   <= div_divisor;
    end else if (fd_cnt != 0 && fd_cnt < ITER) fd_cnt <= fd_cnt + 1;
    else fd_cnt <= 0;
  end
  assign div_quotient = (fd_cnt == ITER) ? fake_div(fd_a, fd_b) : 32'hDEAD_BEEF;

  // Transaction-level reference model: one job outstanding at a time.
  bit          mon_en = 0;
  bit          m_busy = 0;
  bit          m_sp = 0;
  int          m_ptr = 0, m_acc = 0, m_done = 0, m_id = 0;
  logic [31:0] m_a = '0, m_b = '0, m_q = '0;
  bit          seen_rv = 0;
  int          first_lat = -1;
  logic [31:0] last_q = '0;
  int          last_id = -1, resp_cnt = 0, last_resp_cyc = 0;
  int          g_id[$];
  int          g_cyc[$];
  int          pick;
  logic [N-1:0] exp_rdy;
  bit          exp_rv;
  logic [32:0] sp;

  always @(negedge clk) begin
    if (mon_en) begin
      pick = -1;
      if (!m_busy)
        for (int k = 0; k < N; k++)
          if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      exp_rv = m_busy && (cyc >= m_done);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("div_load", 32'(div_load), 32'(m_busy && !m_sp && cyc == m_acc + 1));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("div_dividend", div_dividend, m_a);
      chk("div_divisor", div_divisor, m_b);
      if (exp_rv) begin
        chk("resp_quotient", resp_quotient, m_q);
        chk("resp_id", 32'(resp_id), 32'(m_id));
      end
      if (m_busy && resp_valid && !seen_rv) begin
        seen_rv   = 1;
        first_lat = cyc - m_acc;
      end
      if (rst) begin
        m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0;
      end else if (m_busy) begin
        if (exp_rv && resp_ready) begin
          m_busy = 0;
          last_q = resp_quotient;
          last_id = int'(resp_id);
          resp_cnt++;
          last_resp_cyc = cyc;
        end
      end else if (pick >= 0) begin
        m_busy = 1; m_acc = cyc; m_id = pick;
        m_a = op_a[pick]; m_b = op_b[pick];
        m_ptr = (pick + 1) % N;
        seen_rv = 0; first_lat = -1;
`ifdef SRT_SCHED_SPECIAL_EN
        sp = spec_dec(m_a, m_b);
`else
        sp = 33'd0;
`endif
        m_sp   = sp[32];
        m_q    = m_sp ? sp[31:0] : fake_div(m_a, m_b);
        m_done = m_sp ? cyc + 1 : cyc + ITER + 2;
        g_id.push_back(pick);
        g_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (m_busy && n < maxc) begin step(); n++; end
    chk("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h7F80_0000;
      2: v = 32'h7FC0_0000;
      default: v = $urandom;
    endcase
    v[31] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
  } vec_t;
  vec_t vt[5];

  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    int rc0 = resp_cnt;
    op_a[v.id] = v.a;
    op_b[v.id] = v.b;
    req_valid = 4'(1) << v.id;
    step();
    req_valid = '0;
    while (resp_cnt == rc0 && n < 60) begin step(); n++; end
    chk($sformatf("vec%0d_done", idx), 32'(resp_cnt - rc0), 32'd1);
    chk($sformatf("vec%0d_quot", idx), last_q, v.q);
    chk($sformatf("vec%0d_id", idx), 32'(last_id), 32'(v.id));
    chk($sformatf("vec%0d_lat", idx), 32'(first_lat), 32'(v.lat));
  endtask

  task automatic set_normal_ops();
    for (int k = 0; k < N; k++) begin
      op_a[k] = 32'h4040_0000 + 32'(k << 20);
      op_b[k] = 32'h4000_0000;
    end
  endtask

  initial begin
    int n, gc, g0;
    logic [31:0] q0;
    logic [1:0]  id0;

    vt[0] = '{2, 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 15};
    vt[1] = '{0, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 15};
    vt[2] = '{3, 32'hC040_0000, 32'h4000_0000, 32'hBFC0_0000, 15};
`ifdef SRT_SCHED_SPECIAL_EN
    vt[3] = '{1, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1};
    vt[4] = '{2, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1};
`else
    vt[3] = '{1, 32'h3F80_0000, 32'h0000_0000, 32'h7F00_0000, 15};
    vt[4] = '{2, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 15};
`endif

    rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin op_a[k] = '0; op_b[k] = '0; end
    @(posedge clk); #1;
    mon_en = 1;
    step(); step();
    chk("rst_resp_quotient", resp_quotient, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    chk("rst_div_divisor", div_divisor, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 5; v++) run_vec(v, vt[v]);

    // Fairness with every requester asserting.
    rst = 1'b1; step(); rst = 1'b0;
    set_normal_ops();
    g0 = g_id.size();
    req_valid = 4'hF;
    n = 0;
    while (g_id.size() < g0 + 5 && n < 200) begin step(); n++; end
    req_valid = '0;
    chk("fair_count", 32'(g_id.size() - g0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (g0 + k < g_id.size()) begin
        chk($sformatf("fair_id%0d", k), 32'(g_id[g0 + k]), 32'(k % 4));
        if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(g_cyc[g0 + k] - g_cyc[g0 + k - 1]), 32'd16);
      end
    end
    wait_idle(40);

    // Backpressure in DONE.
    step();
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    step();
    req_valid = 4'hF;
    n = 0;
    while (!resp_valid && n < 40) begin step(); n++; end
    chk("bp_reached", 32'(resp_valid), 32'd1);
    q0 = resp_quotient; id0 = resp_id;
    chk("bp_id", 32'(id0), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_q_stable", resp_quotient, q0);
      chk("bp_id_stable", 32'(resp_id), 32'(id0));
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    gc = g_id.size();
    step();
    step();
    req_valid = '0;
    chk("bp_next_grant", 32'(g_id.size() - gc), 32'd1);
    if (g_id.size() > gc) begin
      chk("bp_next_id", 32'(g_id[gc]), 32'd2);
      chk("bp_next_gap", 32'(g_cyc[gc] - last_resp_cyc), 32'd1);
    end
    wait_idle(40);

    // Reset while iterating with cnt at 5.
    step();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n = 0;
    while (!div_load && n < 10) begin step(); n++; end
    chk("rm_load_seen", 32'(div_load), 32'd1);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_resp_quotient", resp_quotient, 32'd0);
    chk("rm_div_dividend", div_dividend, 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_resp_valid", 32'(resp_valid), 32'd0);
    repeat (20) step();
    gc = g_id.size();
    req_valid = 4'hF;
    step();
    req_valid = '0;
    if (g_id.size() > gc) chk("rm_ptr_zero", 32'(g_id[gc]), 32'd0);
    else chk("rm_grant_seen", 32'(g_id.size() - gc), 32'd1);
    wait_idle(40);

    // Requester 1 valid for a single IDLE cycle behind requester 0.
    rst = 1'b1; step(); rst = 1'b0;
    gc = g_id.size();
    req_valid = 4'b0011;
    step();
    req_valid = '0;
    wait_idle(40);
    repeat (3) step();
    chk("drop_count", 32'(g_id.size() - gc), 32'd1);
    if (g_id.size() > gc) chk("drop_id", 32'(g_id[gc]), 32'd0);

    // Randomized traffic, backpressure and occasional reset.
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < N; k++) begin op_a[k] = rnd_op(); op_b[k] = rnd_op(); end
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    wait_idle(60);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

endmodule
